// File: rtl/pipe_pkg.sv
// Shared types and default constants for the elastic pipeline-stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } state_e;

    localparam int PIPE_WIDTH_DEF = 32;
    localparam int PIPE_CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-wide data register: async reset and sync clear to RESET_VAL, load enable.
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_clr) begin
            r_q <= RESET_VAL;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage with a one-entry skid buffer; in_ready comes straight from state flops.
// Optional stall counter enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = PIPE_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipe_skid_reg: WIDTH and CNT_W must be at least 1");
    end

    state_e           r_state;
    state_e           w_next;
    logic             w_main_ld;
    logic             w_skid_ld;
    logic             w_main_from_skid;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_skid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_main_ld        = 1'b0;
        w_skid_ld        = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (in_valid) begin
                    w_main_ld = 1'b1;
                    w_next    = FULL;
                end
            end
            FULL: begin
                if (in_valid && out_ready) begin
                    w_main_ld = 1'b1;
                end else if (in_valid) begin
                    w_skid_ld = 1'b1;
                    w_next    = SKID;
                end else if (out_ready) begin
                    w_next    = EMPTY;
                end
            end
            SKID: begin
                // in_ready is low here, so in_valid is ignored
                if (out_ready) begin
                    w_main_ld        = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_next           = FULL;
                end
            end
            default: w_next = EMPTY;
        endcase
        if (flush) begin
            w_next = EMPTY;
        end
    end

    assign w_main_d  = w_main_from_skid ? w_skid_q : in_data;
    assign out_valid = (r_state != EMPTY);
    assign in_ready  = (r_state != SKID);

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_ld  (w_main_ld),
        .i_d   (w_main_d),
        .o_q   (out_data)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_ld  (w_skid_ld),
        .i_d   (in_data),
        .o_q   (w_skid_q)
    );

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Only rst clears the counter so stalls survive pipeline flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Table-driven bench for pipe_skid_reg with a FIFO scoreboard; perf checks when PIPE_SKID_PERF_EN is defined.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_SKID_PERF_EN
    logic [15:0] stall_cnt;
    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_out_data;
    logic [2:0]  sat_stall_cnt;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_od;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

`ifdef PIPE_SKID_PERF_EN
    pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0), .CNT_W(3)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (sat_in_ready),
        .in_data   (in_data),
        .out_valid (sat_out_valid),
        .out_ready (out_ready),
        .out_data  (sat_out_data),
        .stall_cnt (sat_stall_cnt)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, update the scoreboard model, then sample #1 after the edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        logic m_ir;
        logic m_ov;
        m_ir      = (sb.size() < 2);
        m_ov      = (sb.size() > 0);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        if (m_ov && ordy) begin
            chk("sb_order", out_data, sb.pop_front());
        end
        if (fl) begin
            sb.delete();
        end else if (iv && m_ir) begin
            sb.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("model_out_valid", {31'b0, out_valid}, {31'b0, (sb.size() > 0)});
        chk("model_in_ready", {31'b0, in_ready}, {31'b0, (sb.size() < 2)});
    endtask

    task automatic async_reset();
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("async_rst_out_data", out_data, 32'h0);
        sb.delete();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11});
        vecs.push_back('{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22});
        vecs.push_back('{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33});
        vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h33});
        vecs.push_back('{1'b1, 32'hA0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0});
        vecs.push_back('{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA0});
        vecs.push_back('{1'b1, 32'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA0});
        vecs.push_back('{1'b1, 32'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA1});
        vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA1});
        vecs.push_back('{1'b1, 32'hB0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB0});
        vecs.push_back('{1'b1, 32'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB0});
        vecs.push_back('{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB2});
        vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hB2});
        vecs.push_back('{1'b1, 32'hC0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC0});
        vecs.push_back('{1'b1, 32'hC1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'hD0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD0});
        vecs.push_back('{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'hD0});
        vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hD0});
        vecs.push_back('{1'b1, 32'hE0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hE0});
        vecs.push_back('{1'b1, 32'hE1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hE0});
        vecs.push_back('{1'b1, 32'hE2, 1'b1, 1'b0, 1'b1, 1'b1, 32'hE1});
        vecs.push_back('{1'b1, 32'hE2, 1'b1, 1'b0, 1'b1, 1'b1, 32'hE2});
        vecs.push_back('{0, 32'h0,     1'b1, 1'b0, 1'b0, 1'b1, 32'hE2});

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_data", out_data, 32'h0);

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
            chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
            chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
        end

        step(1'b1, 32'h55, 1'b0, 1'b0);
        chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
        async_reset();
        step(1'b1, 32'h66, 1'b1, 1'b0);
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd1);
        chk("post_rst_out_data", out_data, 32'h66);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_rst_drain", {31'b0, out_valid}, 32'd0);

`ifdef PIPE_SKID_PERF_EN
        async_reset();
        chk("perf_reset_cnt", {16'b0, stall_cnt}, 32'd0);
        step(1'b1, 32'h77, 1'b0, 1'b0);
        chk("perf_first_load", {16'b0, stall_cnt}, 32'd0);
        repeat (10) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("perf_stall10", {16'b0, stall_cnt}, 32'd10);
        chk("perf_sat_stall10", {29'b0, sat_stall_cnt}, 32'd7);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("perf_stall12", {16'b0, stall_cnt}, 32'd12);
        chk("perf_sat_stall12", {29'b0, sat_stall_cnt}, 32'd7);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("perf_flush_keeps", {16'b0, stall_cnt}, 32'd13);
`endif

        chk("sb_empty_at_end", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
